// File: rtl/div23_pkg.sv
// Shared constants and FSM state type for the divide-by-23 sequencer.
package div23_pkg;

  localparam int DIVISOR = 23;   // only divisor the step logic supports
  localparam int STEPS   = 22;   // 3-bit digit steps per 64-bit operation
  localparam int DIGIT_W = 3;    // quotient bits retired per step
  localparam int REM_W   = 5;    // remainder width, holds 0..22
  localparam int CHUNK_W = REM_W + DIGIT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div23_step.sv
// One radix-8 long-division digit: chunk (< 184) split into quotient digit
// and remainder by three restoring compare/subtract stages.
module div23_step #(
  parameter int DIVISOR = 23
) (
  input  logic [7:0] chunk,
  output logic [2:0] q,
  output logic [4:0] r
);

  localparam logic [7:0] D1 = 8'(DIVISOR);
  localparam logic [7:0] D2 = 8'(DIVISOR * 2);
  localparam logic [7:0] D4 = 8'(DIVISOR * 4);

  logic [7:0] work;

  // Restoring division against 4D, 2D and D, one quotient bit each.
  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise a path
    // that skips an assignment would infer a latch.
    work = chunk;
    q    = '0;
    if (work >= D4) begin
      q[2] = 1'b1;
      work = work - D4;
    end
    if (work >= D2) begin
      q[1] = 1'b1;
      work = work - D2;
    end
    if (work >= D1) begin
      q[0] = 1'b1;
      work = work - D1;
    end
    r = work[4:0];
  end

endmodule

// File: rtl/div23_seq_ctrl.sv
// Sequential unsigned divide-by-23: one 3-bit quotient digit per BUSY cycle,
// valid/ready handshake on both the dividend and result sides.
module div23_seq_ctrl #(
  parameter int DW      = 64,
  parameter int DIVISOR = div23_pkg::DIVISOR,
  parameter int STEPS   = div23_pkg::STEPS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_dividend,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_quot,
  output logic [4:0]    out_rem,
  output logic          busy
);

  import div23_pkg::*;

  localparam int SW = STEPS * DIGIT_W;        // zero-extended dividend width
  localparam int CW = $clog2(STEPS + 1);

  state_t              state;
  state_t              state_nxt;
  logic [SW-1:0]       dvd;
  // The quotient of a DW-bit dividend fits in DW bits, so the two extra
  // digit bits the full SW-bit shift would carry are always zero and dropped.
  logic [DW-1:0]       quot;
  logic [REM_W-1:0]    rem;
  logic [CW-1:0]       cnt;
  logic [DIGIT_W-1:0]  q3;
  logic [REM_W-1:0]    r5;
  logic                accept;
  logic                last_step;

  assign in_ready  = rst_n && (state == IDLE);
  assign accept    = in_valid && in_ready;
  assign last_step = (cnt == CW'(STEPS - 1));
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_quot  = quot;
  assign out_rem   = rem;

  div23_step #(.DIVISOR(DIVISOR)) u_step (
    .chunk ({rem, dvd[SW-1 -: DIGIT_W]}),
    .q     (q3),
    .r     (r5)
  );

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept -> run STEPS digits -> hold result until taken.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)    state_nxt = BUSY;
      BUSY:    if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Datapath: load on acceptance, retire one digit per BUSY cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd  <= '0;
      quot <= '0;
      rem  <= '0;
      cnt  <= '0;
    end else if (accept) begin
      dvd  <= {{(SW-DW){1'b0}}, in_dividend};
      quot <= '0;
      rem  <= '0;
      cnt  <= '0;
    end else if (state == BUSY) begin
      rem  <= r5;
      quot <= {quot[DW-DIGIT_W-1:0], q3};
      dvd  <= dvd << DIGIT_W;
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_div23_seq_ctrl.sv
// Self-checking bench for div23_seq_ctrl: directed cases with hand-computed
// results plus a randomized regression against a transaction-level model.
module tb_div23_seq_ctrl;

  localparam int DW    = 64;
  localparam int STEPS = 22;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_dividend = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_quot;
  logic [4:0]    out_rem;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div23_seq_ctrl #(.DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dividend (in_dividend),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_quot    (out_quot),
    .out_rem     (out_rem),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: the result is plain integer division taken
  // at acceptance; it becomes visible STEPS edges later and is held until taken.
  typedef enum {M_IDLE, M_BUSY, M_DONE} mph_t;
  mph_t        m_ph = M_IDLE;
  int          m_left = 0;
  logic [63:0] m_q = '0;
  logic [4:0]  m_r = '0;
  bit          m_ok = 1'b0;
  int          n_acc = 0;
  int          n_done = 0;
  int          n_abort = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      if (m_ok && m_ph != M_IDLE) n_abort++;
      m_ph = M_IDLE;
      m_ok = 1'b1;
    end else if (m_ok) begin
      case (m_ph)
        M_IDLE: if (in_valid) begin
          m_q    = in_dividend / 64'd23;
          m_r    = 5'(in_dividend % 64'd23);
          m_left = STEPS;
          m_ph   = M_BUSY;
          n_acc++;
        end
        M_BUSY: begin
          m_left--;
          if (m_left == 0) m_ph = M_DONE;
        end
        M_DONE: if (out_ready) begin
          m_ph = M_IDLE;
          n_done++;
        end
        default: m_ph = M_IDLE;
      endcase
    end
  end

  // Per-cycle compare, sampled mid-low-phase after inputs have settled.
  always begin
    @(negedge clk);
    #2;
    if (m_ok) begin
      check("in_ready", in_ready, rst_n && (m_ph == M_IDLE));
      check("busy", busy, m_ph != M_IDLE);
      check("out_valid", out_valid, m_ph == M_DONE);
      if (m_ph == M_DONE) begin
        check("out_quot", out_quot, m_q);
        check("out_rem", out_rem, m_r);
      end
    end
  end

  bit rand_mode = 1'b0;
  always @(negedge clk) if (rand_mode) out_ready = ($urandom % 4) != 0;

  // Offer a dividend (caller sits at a negedge); returns the accepting edge time.
  task automatic send(input logic [63:0] d, output time ta);
    bit ok = 1'b0;
    ta = 0;
    in_valid    = 1'b1;
    in_dividend = d;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        ta = $time;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    in_valid    = 1'b0;
    in_dividend = {$urandom, $urandom};
    check("accepted", ok, 1'b1);
  endtask

  // Wait (bounded) for out_valid; returns the negedge time it was seen.
  task automatic wait_result(output time tv);
    bit found = 1'b0;
    tv = 0;
    for (int i = 0; i < 100; i++) begin
      tv = $time;
      #1;
      if (out_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("valid_seen", found, 1'b1);
  endtask

  task automatic handoff(output time th);
    out_ready = 1'b1;
    @(posedge clk);
    th = $time;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("post_handoff_valid", out_valid, 1'b0);
    check("post_handoff_ready", in_ready, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    time ta, tv, th, ta2;
    bit  seen;
    logic [63:0] d;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_quot", out_quot, 64'd0);
    check("rst_rem", out_rem, 5'd0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1'b1);

    // 1000 / 23 = 43 r 11, valid exactly 22 edges after acceptance.
    send(64'd1000, ta);
    wait_result(tv);
    check("lat_1000", (tv - ta - 5) / 10, 22);
    check("q_1000", out_quot, 64'd43);
    check("r_1000", out_rem, 5'd11);
    handoff(th);

    // Extremes.
    send(64'hFFFF_FFFF_FFFF_FFFF, ta);
    wait_result(tv);
    check("q_max", out_quot, 64'd802032351030850070);
    check("r_max", out_rem, 5'd5);
    handoff(th);
    send(64'd0, ta);
    wait_result(tv);
    check("q_zero", out_quot, 64'd0);
    check("r_zero", out_rem, 5'd0);
    handoff(th);

    // Back-to-back 22 then 23; second accepted one cycle after handoff.
    send(64'd22, ta);
    wait_result(tv);
    check("q_22", out_quot, 64'd0);
    check("r_22", out_rem, 5'd22);
    handoff(th);
    send(64'd23, ta2);
    check("b2b_gap", ta2 - th, 10);
    wait_result(tv);
    check("q_23", out_quot, 64'd1);
    check("r_23", out_rem, 5'd0);
    handoff(th);

    // Backpressure: 500 / 23 = 21 r 17 held for 10 cycles.
    send(64'd500, ta);
    wait_result(tv);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("hold_quot", out_quot, 64'd21);
      check("hold_rem", out_rem, 5'd17);
      check("hold_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
    end
    handoff(th);

    // Abort mid-operation.
    send(64'd777, ta);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready_low", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_valid", out_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_valid", seen, 1'b0);
    send(64'd46, ta);
    wait_result(tv);
    check("q_46", out_quot, 64'd2);
    check("r_46", out_rem, 5'd0);
    handoff(th);

    // Randomized regression with random gaps and consumer backpressure.
    rand_mode = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      case ($urandom % 4)
        0:       d = {$urandom, $urandom};
        1:       d = 64'($urandom_range(0, 200));
        2:       d = 64'd23 * {32'd0, $urandom} + 64'($urandom_range(0, 1) * 22);
        default: d = ~64'($urandom_range(0, 50));
      endcase
      send(d, ta);
    end
    rand_mode = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (m_ph == M_IDLE) break;
    end
    out_ready = 1'b0;
    @(negedge clk);
    check("drain_idle", busy, 1'b0);
    check("scoreboard", n_done + n_abort, n_acc);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
